pagamento_troco: RTL and testbench

- Payment and dispense side of the vending machine; consumes the product selection produced by keypad entry.
- Accumulates coin credit and, on confirmation, checks price against credit.
- Drives the dispense motor with a request/acknowledge handshake, then returns change one unit-coin at a time through a second handshake.

---
 rtl/pagamento_troco.sv | 176 +++++++++++++++++
 tb/tb_pagamento_troco.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pagamento_troco.sv
// Vending machine payment side: coin credit, price check, dispense and
// change handshakes.
module pagamento_troco #(
  parameter int CREDITO_MAX   = 15,
  parameter int TIMEOUT_MOTOR = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] moeda,
  input  logic       moeda_valida,
  input  logic [2:0] valor,
  input  logic [3:0] produto,
  input  logic       existe,
  input  logic       OK,
  input  logic       cancela,
  input  logic       motor_pronto,
  input  logic       moeda_ack,
  output logic [3:0] credito,
  output logic       libera,
  output logic [3:0] produto_saida,
  output logic       devolve_moeda,
  output logic       rejeita,
  output logic       erro,
  output logic       falha,
  output logic       ocupado,
  output logic [2:0] estado
);

  localparam int TW = (TIMEOUT_MOTOR > 1) ? $clog2(TIMEOUT_MOTOR) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_MOTOR - 1);
  localparam logic [4:0] CMAX = 5'(CREDITO_MAX);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    VERIFICA = 3'd1,
    LIBERA   = 3'd2,
    TROCO    = 3'd3,
    FIM      = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    credito_q, credito_d;
  logic [3:0]    produto_q, produto_d;
  logic [2:0]    valor_q, valor_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          devolve_q, devolve_d;
  logic          rejeita_q, rejeita_d;
  logic          erro_q, erro_d;
  logic          falha_q, falha_d;

  logic       coin_ev;
  logic [2:0] coin_v;
  logic [4:0] soma;
  logic [4:0] refund;

  always_comb begin
    coin_v = 3'd0;
    unique case (moeda)
      2'b01:   coin_v = 3'd1;
      2'b10:   coin_v = 3'd2;
      2'b11:   coin_v = 3'd5;
      default: coin_v = 3'd0;
    endcase
  end

  assign coin_ev = moeda_valida && (moeda != 2'b00);
  assign soma    = {1'b0, credito_q} + {2'b00, coin_v};
  assign refund  = {1'b0, credito_q} + {2'b00, valor_q};

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_q;
    produto_d = produto_q;
    valor_d   = valor_q;
    timer_d   = timer_q;
    devolve_d = devolve_q;
    rejeita_d = 1'b0;
    erro_d    = 1'b0;
    falha_d   = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        // a coin in the same cycle as a command wins; the command is dropped
        if (coin_ev) begin
          if (soma <= CMAX) credito_d = soma[3:0];
          else              rejeita_d = 1'b1;
        end else if (OK) begin
          estado_d = VERIFICA;
        end else if (cancela && credito_q != 4'd0) begin
          estado_d = TROCO;
        end
      end
      VERIFICA: begin
        rejeita_d = coin_ev;
        if (existe && valor != 3'd0 && credito_q >= {1'b0, valor}) begin
          produto_d = produto;
          valor_d   = valor;
          credito_d = credito_q - {1'b0, valor};
          timer_d   = '0;
          estado_d  = LIBERA;
        end else begin
          erro_d   = 1'b1;
          estado_d = OCIOSO;
        end
      end
      LIBERA: begin
        rejeita_d = coin_ev;
        if (motor_pronto) begin
          estado_d = (credito_q != 4'd0) ? TROCO : FIM;
        end else if (timer_q == TLAST) begin
          falha_d   = 1'b1;
          credito_d = (refund > CMAX) ? CMAX[3:0] : refund[3:0];
          estado_d  = TROCO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TROCO: begin
        rejeita_d = coin_ev;
        if (credito_q == 4'd0) begin
          devolve_d = 1'b0;
          estado_d  = FIM;
        end else if (devolve_q) begin
          // request drops for a cycle after each ack
          if (moeda_ack) begin
            devolve_d = 1'b0;
            credito_d = credito_q - 4'd1;
            if (credito_q == 4'd1) estado_d = FIM;
          end
        end else begin
          devolve_d = 1'b1;
        end
      end
      FIM: begin
        rejeita_d = coin_ev;
        produto_d = 4'd0;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      credito_q <= 4'd0;
      produto_q <= 4'd0;
      valor_q   <= 3'd0;
      timer_q   <= '0;
      devolve_q <= 1'b0;
      rejeita_q <= 1'b0;
      erro_q    <= 1'b0;
      falha_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      produto_q <= produto_d;
      valor_q   <= valor_d;
      timer_q   <= timer_d;
      devolve_q <= devolve_d;
      rejeita_q <= rejeita_d;
      erro_q    <= erro_d;
      falha_q   <= falha_d;
    end
  end

  assign credito       = credito_q;
  assign libera        = (estado_q == LIBERA);
  assign produto_saida = produto_q;
  assign devolve_moeda = devolve_q;
  assign rejeita       = rejeita_q;
  assign erro          = erro_q;
  assign falha         = falha_q;
  assign ocupado       = (estado_q != OCIOSO);
  assign estado        = estado_q;

endmodule

// File: tb/tb_pagamento_troco.sv
// Directed bench for pagamento_troco: coin table plus purchase, refusal,
// cancel, motor timeout and reset sequences.
module tb_pagamento_troco;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] moeda;
  logic       moeda_valida;
  logic [2:0] valor;
  logic [3:0] produto;
  logic       existe;
  logic       OK;
  logic       cancela;
  logic       motor_pronto;
  logic       moeda_ack;
  logic [3:0] credito;
  logic       libera;
  logic [3:0] produto_saida;
  logic       devolve_moeda;
  logic       rejeita;
  logic       erro;
  logic       falha;
  logic       ocupado;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  pagamento_troco #(
    .CREDITO_MAX(15),
    .TIMEOUT_MOTOR(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .moeda(moeda),
    .moeda_valida(moeda_valida),
    .valor(valor),
    .produto(produto),
    .existe(existe),
    .OK(OK),
    .cancela(cancela),
    .motor_pronto(motor_pronto),
    .moeda_ack(moeda_ack),
    .credito(credito),
    .libera(libera),
    .produto_saida(produto_saida),
    .devolve_moeda(devolve_moeda),
    .rejeita(rejeita),
    .erro(erro),
    .falha(falha),
    .ocupado(ocupado),
    .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic [3:0] cred;
    logic       rej;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic coin(input logic [1:0] c);
    moeda = c;
    moeda_valida = 1'b1;
    tick();
    moeda_valida = 1'b0;
    moeda = 2'b00;
  endtask

  task automatic press_ok();
    OK = 1'b1;
    tick();
    OK = 1'b0;
  endtask

  task automatic troco(input int start);
    for (int i = 0; i < start; i++) begin
      int w;
      w = 0;
      while (!devolve_moeda && w < 10) begin
        tick();
        w++;
      end
      chk("devolve_req", devolve_moeda, 1);
      moeda_ack = 1'b1;
      tick();
      moeda_ack = 1'b0;
      chk("troco_cred", credito, start - i - 1);
      chk("devolve_drop", devolve_moeda, 0);
    end
  endtask

  initial begin
    tbl[0] = '{2'b01, 4'd1,  1'b0};
    tbl[1] = '{2'b10, 4'd3,  1'b0};
    tbl[2] = '{2'b00, 4'd3,  1'b0};
    tbl[3] = '{2'b11, 4'd8,  1'b0};
    tbl[4] = '{2'b11, 4'd13, 1'b0};
    tbl[5] = '{2'b10, 4'd15, 1'b0};
    tbl[6] = '{2'b01, 4'd15, 1'b1};
    tbl[7] = '{2'b11, 4'd15, 1'b1};

    reset = 1'b1;
    moeda = 2'b00;
    moeda_valida = 1'b0;
    valor = 3'd0;
    produto = 4'd0;
    existe = 1'b0;
    OK = 1'b0;
    cancela = 1'b0;
    motor_pronto = 1'b0;
    moeda_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_estado", estado, 0);
    chk("rst_credito", credito, 0);
    chk("rst_produto", produto_saida, 0);
    chk("rst_bits", {libera, devolve_moeda, rejeita, erro, falha, ocupado}, 0);

    // coin accumulation and saturation table
    for (int i = 0; i < 8; i++) begin
      coin(tbl[i].m);
      chk($sformatf("tbl%0d_cred", i), credito, tbl[i].cred);
      chk($sformatf("tbl%0d_rej", i), rejeita, tbl[i].rej);
    end
    tick();
    chk("rej_pulse_end", rejeita, 0);

    // 2 at credit 14 refused
    do_reset();
    coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b10);
    chk("cred14", credito, 14);
    coin(2'b10);
    chk("rej14_cred", credito, 14);
    chk("rej14_pulse", rejeita, 1);

    // purchase with change
    do_reset();
    coin(2'b11); coin(2'b10);
    chk("buy_cred7", credito, 7);
    produto = 4'h3; valor = 3'd5; existe = 1'b1;
    press_ok();
    chk("buy_verifica", estado, 1);
    tick();
    chk("buy_libera_st", estado, 2);
    chk("buy_libera", libera, 1);
    chk("buy_prod", produto_saida, 3);
    chk("buy_cred2", credito, 2);
    produto = 4'h0;
    coin(2'b11);
    chk("lib_coin_rej", rejeita, 1);
    chk("lib_coin_cred", credito, 2);
    chk("lib_prod_hold", produto_saida, 3);
    tick();
    motor_pronto = 1'b1;
    tick();
    motor_pronto = 1'b0;
    chk("buy_troco_st", estado, 3);
    chk("buy_lib_drop", libera, 0);
    troco(2);
    chk("buy_fim", estado, 4);
    tick();
    chk("buy_ocioso", estado, 0);
    chk("buy_prod_clr", produto_saida, 0);
    chk("buy_ocupado", ocupado, 0);

    // refused confirmations
    do_reset();
    coin(2'b10); coin(2'b01);
    valor = 3'd5; existe = 1'b1;
    press_ok();
    tick();
    chk("erro_price", erro, 1);
    chk("erro_price_st", estado, 0);
    chk("erro_price_cred", credito, 3);
    tick();
    chk("erro_pulse_end", erro, 0);
    valor = 3'd2; existe = 1'b0;
    press_ok();
    tick();
    chk("erro_existe", erro, 1);
    chk("erro_existe_cred", credito, 3);
    valor = 3'd0; existe = 1'b1;
    press_ok();
    tick();
    chk("erro_valor0", erro, 1);
    chk("erro_valor0_st", estado, 0);

    // cancel with credit 4, then cancel at 0
    do_reset();
    coin(2'b10); coin(2'b10);
    cancela = 1'b1;
    tick();
    cancela = 1'b0;
    chk("canc_troco", estado, 3);
    troco(4);
    chk("canc_fim", estado, 4);
    tick();
    chk("canc_ocupado", ocupado, 0);
    cancela = 1'b1;
    tick();
    cancela = 1'b0;
    chk("canc0_st", estado, 0);

    // motor timeout refunds the price
    do_reset();
    coin(2'b11); coin(2'b01);
    valor = 3'd4; existe = 1'b1; produto = 4'h9;
    press_ok();
    tick();
    chk("to_libera", estado, 2);
    chk("to_cred2", credito, 2);
    begin
      int n;
      n = 0;
      while (!falha && n < 20) begin
        tick();
        n++;
      end
      chk("to_cycles", n, 8);
    end
    chk("to_cred6", credito, 6);
    chk("to_troco", estado, 3);
    chk("to_lib_drop", libera, 0);
    tick();
    chk("to_falha_end", falha, 0);
    troco(6);
    tick();
    chk("to_ocioso", estado, 0);

    // asynchronous reset mid-LIBERA
    do_reset();
    coin(2'b11);
    valor = 3'd2; existe = 1'b1; produto = 4'h7;
    press_ok();
    tick();
    chk("mid_lib_st", estado, 2);
    reset = 1'b1;
    #1;
    chk("rl_estado", estado, 0);
    chk("rl_credito", credito, 0);
    chk("rl_produto", produto_saida, 0);
    chk("rl_bits", {libera, devolve_moeda, rejeita, erro, falha, ocupado}, 0);
    #2;
    reset = 1'b0;
    tick();

    // asynchronous reset mid-TROCO
    coin(2'b11);
    cancela = 1'b1;
    tick();
    cancela = 1'b0;
    tick();
    chk("mid_tr_dev", devolve_moeda, 1);
    reset = 1'b1;
    #1;
    chk("rt_estado", estado, 0);
    chk("rt_credito", credito, 0);
    chk("rt_bits", {libera, devolve_moeda, rejeita, erro, falha, ocupado}, 0);
    #2;
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
